// File: rtl/axi_resp_mux_n_if.sv
// Bundle of master-side request/handshake signals, per-slave response vectors and
// merged outputs for axi_resp_mux_n. The 'slave' modport is the mux's own view.
interface axi_resp_mux_n_if #(
    parameter int N_SLV  = 2,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) ();
    logic                      m_awvalid;
    logic [ID_W-1:0]           m_awid;
    logic                      m_wvalid;
    logic                      m_wlast;
    logic                      m_bready;
    logic                      m_arvalid;
    logic [ID_W-1:0]           m_arid;
    logic [7:0]                m_arlen;
    logic                      m_rready;

    logic [N_SLV-1:0]          s_awready;
    logic [N_SLV-1:0]          s_wready;
    logic [N_SLV*ID_W-1:0]     s_bid;
    logic [2*N_SLV-1:0]        s_bresp;
    logic [N_SLV-1:0]          s_bvalid;
    logic [N_SLV-1:0]          s_arready;
    logic [N_SLV*ID_W-1:0]     s_rid;
    logic [N_SLV*DATA_W-1:0]   s_rdata;
    logic [2*N_SLV-1:0]        s_rresp;
    logic [N_SLV-1:0]          s_rlast;
    logic [N_SLV-1:0]          s_rvalid;

    logic                      awready;
    logic                      wready;
    logic                      bvalid;
    logic                      arready;
    logic                      rlast;
    logic                      rvalid;
    logic [ID_W-1:0]           bid;
    logic [ID_W-1:0]           rid;
    logic [1:0]                bresp;
    logic [1:0]                rresp;
    logic [DATA_W-1:0]         rdata;
    logic                      err_multi;
    logic [15:0]               err_timeout_cnt;

    modport slave (
        input  m_awvalid, m_awid, m_wvalid, m_wlast, m_bready,
               m_arvalid, m_arid, m_arlen, m_rready,
               s_awready, s_wready, s_bid, s_bresp, s_bvalid,
               s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output awready, wready, bvalid, arready, rlast, rvalid,
               bid, rid, bresp, rresp, rdata, err_multi, err_timeout_cnt
    );

    modport master (
        output m_awvalid, m_awid, m_wvalid, m_wlast, m_bready,
               m_arvalid, m_arid, m_arlen, m_rready,
               s_awready, s_wready, s_bid, s_bresp, s_bvalid,
               s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  awready, wready, bvalid, arready, rlast, rvalid,
               bid, rid, bresp, rresp, rdata, err_multi, err_timeout_cnt
    );
endinterface

// File: rtl/axi_resp_mux_n.sv
// N-way AXI response combiner: the slave that takes an address owns its channel
// until the response completes; unclaimed requests time out and return DECERR.
module axi_resp_mux_n #(
    parameter int N_SLV       = 2,
    parameter int ID_W        = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    axi_resp_mux_n_if.slave   bus
);
    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {W_IDLE, W_OWN, W_DEC_W, W_DEC_B} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_OWN, R_DEC} r_state_e;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SLV-1:0] v);
        lowest_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (v[k]) lowest_idx = IDX_W'(k);
        end
    endfunction

    function automatic logic multi_hot(input logic [N_SLV-1:0] v);
        multi_hot = (v & (v - N_SLV'(1))) != '0;
    endfunction

    w_state_e          w_state_q, w_state_d;
    logic [IDX_W-1:0]  w_owner_q, w_owner_d;
    logic [TMR_W-1:0]  w_tmr_q, w_tmr_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic              w_claim, w_to;

    r_state_e          r_state_q, r_state_d;
    logic [IDX_W-1:0]  r_owner_q, r_owner_d;
    logic [TMR_W-1:0]  r_tmr_q, r_tmr_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [8:0]        r_beats_q, r_beats_d;
    logic              r_claim, r_to;

    logic              err_multi_q, err_multi_d;
    logic [15:0]       err_to_q, err_to_d;
    logic [16:0]       to_sum;

    logic              awready, wready, bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arready, rvalid, rlast;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    // Write channel
    always_comb begin
        w_state_d = w_state_q;
        w_owner_d = w_owner_q;
        w_tmr_d   = '0;
        w_id_d    = w_id_q;
        w_claim   = 1'b0;
        w_to      = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = 2'b00;
        unique case (w_state_q)
            W_IDLE: begin
                awready = |bus.s_awready;
                if (bus.m_awvalid && (|bus.s_awready)) begin
                    w_claim   = 1'b1;
                    w_owner_d = lowest_idx(bus.s_awready);
                    w_state_d = W_OWN;
                end else if (bus.m_awvalid) begin
                    if (w_tmr_q == TMR_LAST) begin
                        awready   = 1'b1;
                        w_to      = 1'b1;
                        w_id_d    = bus.m_awid;
                        w_state_d = W_DEC_W;
                    end else begin
                        w_tmr_d = w_tmr_q + TMR_ONE;
                    end
                end
            end
            W_OWN: begin
                wready = bus.s_wready[w_owner_q];
                bvalid = bus.s_bvalid[w_owner_q];
                bid    = bus.s_bid[w_owner_q*ID_W +: ID_W];
                bresp  = bus.s_bresp[w_owner_q*2 +: 2];
                if (bvalid && bus.m_bready) w_state_d = W_IDLE;
            end
            W_DEC_W: begin
                wready = 1'b1;
                if (bus.m_wvalid && bus.m_wlast) w_state_d = W_DEC_B;
            end
            W_DEC_B: begin
                bvalid = 1'b1;
                bresp  = 2'b11;
                bid    = w_id_q;
                if (bus.m_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel
    always_comb begin
        r_state_d = r_state_q;
        r_owner_d = r_owner_q;
        r_tmr_d   = '0;
        r_id_d    = r_id_q;
        r_beats_d = r_beats_q;
        r_claim   = 1'b0;
        r_to      = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rid       = '0;
        rresp     = 2'b00;
        rdata     = '0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = |bus.s_arready;
                if (bus.m_arvalid && (|bus.s_arready)) begin
                    r_claim   = 1'b1;
                    r_owner_d = lowest_idx(bus.s_arready);
                    r_state_d = R_OWN;
                end else if (bus.m_arvalid) begin
                    if (r_tmr_q == TMR_LAST) begin
                        arready   = 1'b1;
                        r_to      = 1'b1;
                        r_id_d    = bus.m_arid;
                        r_beats_d = {1'b0, bus.m_arlen} + 9'd1;
                        r_state_d = R_DEC;
                    end else begin
                        r_tmr_d = r_tmr_q + TMR_ONE;
                    end
                end
            end
            R_OWN: begin
                rvalid = bus.s_rvalid[r_owner_q];
                rlast  = bus.s_rlast[r_owner_q];
                rid    = bus.s_rid[r_owner_q*ID_W +: ID_W];
                rresp  = bus.s_rresp[r_owner_q*2 +: 2];
                rdata  = bus.s_rdata[r_owner_q*DATA_W +: DATA_W];
                if (rvalid && rlast && bus.m_rready) r_state_d = R_IDLE;
            end
            R_DEC: begin
                rvalid = 1'b1;
                rresp  = 2'b11;
                rid    = r_id_q;
                rlast  = (r_beats_q == 9'd1);
                if (bus.m_rready) begin
                    r_beats_d = r_beats_q - 9'd1;
                    if (rlast) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Both channels may time out in the same cycle, so the count can step by two
    always_comb begin
        to_sum      = {1'b0, err_to_q} + 17'(w_to) + 17'(r_to);
        err_to_d    = to_sum[16] ? 16'hFFFF : to_sum[15:0];
        err_multi_d = err_multi_q
                    | (w_claim && multi_hot(bus.s_awready))
                    | (r_claim && multi_hot(bus.s_arready));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            w_owner_q   <= '0;
            w_tmr_q     <= '0;
            w_id_q      <= '0;
            r_state_q   <= R_IDLE;
            r_owner_q   <= '0;
            r_tmr_q     <= '0;
            r_id_q      <= '0;
            r_beats_q   <= '0;
            err_multi_q <= 1'b0;
            err_to_q    <= '0;
        end else begin
            w_state_q   <= w_state_d;
            w_owner_q   <= w_owner_d;
            w_tmr_q     <= w_tmr_d;
            w_id_q      <= w_id_d;
            r_state_q   <= r_state_d;
            r_owner_q   <= r_owner_d;
            r_tmr_q     <= r_tmr_d;
            r_id_q      <= r_id_d;
            r_beats_q   <= r_beats_d;
            err_multi_q <= err_multi_d;
            err_to_q    <= err_to_d;
        end
    end

    // Outputs are held at zero while reset is asserted
    assign bus.awready         = awready & ~rst;
    assign bus.wready          = wready & ~rst;
    assign bus.bvalid          = bvalid & ~rst;
    assign bus.bid             = rst ? '0 : bid;
    assign bus.bresp           = rst ? 2'b00 : bresp;
    assign bus.arready         = arready & ~rst;
    assign bus.rvalid          = rvalid & ~rst;
    assign bus.rlast           = rlast & ~rst;
    assign bus.rid             = rst ? '0 : rid;
    assign bus.rresp           = rst ? 2'b00 : rresp;
    assign bus.rdata           = rst ? '0 : rdata;
    assign bus.err_multi       = err_multi_q & ~rst;
    assign bus.err_timeout_cnt = rst ? 16'h0000 : err_to_q;

endmodule

// File: tb/tb_axi_resp_mux_n.sv
// Randomized bench for axi_resp_mux_n with a transaction-level reference model
// (lowest-index owner, sticky multi-claim flag, timeout count).
module tb_axi_resp_mux_n;
    localparam int N    = 4;
    localparam int IW   = 4;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int IDV  = N * IW;
    localparam int RSV  = 2 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_resp_mux_n_if #(.N_SLV(N), .ID_W(IW), .DATA_W(DW)) bus ();

    axi_resp_mux_n #(.N_SLV(N), .ID_W(IW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit exp_multi = 1'b0;
    int exp_to    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) if (m[k]) return k;
        return -1;
    endfunction

    function automatic int popc(input logic [N-1:0] m);
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(m[k]);
        return c;
    endfunction

    task automatic clear_w();
        bus.m_awvalid = 0; bus.m_awid = '0; bus.m_wvalid = 0; bus.m_wlast = 0; bus.m_bready = 0;
        bus.s_awready = '0; bus.s_wready = '0; bus.s_bid = '0; bus.s_bresp = '0; bus.s_bvalid = '0;
    endtask

    task automatic clear_r();
        bus.m_arvalid = 0; bus.m_arid = '0; bus.m_arlen = '0; bus.m_rready = 0;
        bus.s_arready = '0; bus.s_rid = '0; bus.s_rdata = '0; bus.s_rresp = '0;
        bus.s_rlast = '0; bus.s_rvalid = '0;
    endtask

    // mask==0: nobody claims, expect timeout + DECERR
    task automatic do_write(input logic [N-1:0] mask, input logic [IW-1:0] id, input int nbeats);
        int own, b, guard;
        bit done;
        b = 0; guard = 0; done = 0;
        if (mask != '0) begin
            own = lowest(mask);
            @(negedge clk);
            bus.m_awvalid = 1; bus.m_awid = id; bus.s_awready = mask;
            #1 check_val("aw_claim_awready", 64'(bus.awready), 64'(1));
            if (popc(mask) > 1) exp_multi = 1'b1;
            @(negedge clk);
            bus.m_awvalid = 0; bus.s_awready = N'($urandom);
            #1 check_val("aw_own_awready", 64'(bus.awready), 64'(0));
            while (b < nbeats && guard < 200) begin
                @(negedge clk);
                bus.m_wvalid = 1; bus.m_wlast = (b == nbeats - 1);
                bus.s_wready = N'($urandom);
                #1 check_val("w_own_wready", 64'(bus.wready), 64'(bus.s_wready[own]));
                if (bus.s_wready[own]) b++;
                guard++;
            end
            check_val("w_own_beats", 64'(b), 64'(nbeats));
            guard = 0;
            while (!done && guard < 200) begin
                @(negedge clk);
                bus.m_wvalid = 0; bus.m_wlast = 0;
                bus.s_bvalid = N'($urandom); bus.s_bid = IDV'($urandom);
                bus.s_bresp = RSV'($urandom); bus.m_bready = 1'($urandom_range(0, 1));
                #1;
                check_val("b_own_bvalid", 64'(bus.bvalid), 64'(bus.s_bvalid[own]));
                check_val("b_own_bid", 64'(bus.bid), 64'(bus.s_bid[own*IW +: IW]));
                check_val("b_own_bresp", 64'(bus.bresp), 64'(bus.s_bresp[own*2 +: 2]));
                if (bus.s_bvalid[own] && bus.m_bready) done = 1;
                guard++;
            end
            check_val("b_own_done", 64'(done), 64'(1));
        end else begin
            for (int c = 1; c <= TO; c++) begin
                @(negedge clk);
                bus.m_awvalid = 1; bus.m_awid = id; bus.s_awready = '0;
                #1 check_val("aw_to_awready", 64'(bus.awready), 64'(c == TO));
            end
            exp_to = (exp_to < 16'hFFFF) ? exp_to + 1 : exp_to;
            while (b < nbeats && guard < 200) begin
                @(negedge clk);
                bus.m_awvalid = 0;
                bus.m_wvalid = 1'($urandom_range(0, 1)); bus.m_wlast = (b == nbeats - 1);
                #1 check_val("w_dec_wready", 64'(bus.wready), 64'(1));
                if (bus.m_wvalid) b++;
                guard++;
            end
            check_val("w_dec_beats", 64'(b), 64'(nbeats));
            guard = 0;
            while (!done && guard < 200) begin
                @(negedge clk);
                bus.m_wvalid = 0; bus.m_wlast = 0; bus.m_bready = 1'($urandom_range(0, 1));
                #1;
                check_val("b_dec_bvalid", 64'(bus.bvalid), 64'(1));
                check_val("b_dec_bresp", 64'(bus.bresp), 64'(3));
                check_val("b_dec_bid", 64'(bus.bid), 64'(id));
                if (bus.m_bready) done = 1;
                guard++;
            end
            check_val("b_dec_done", 64'(done), 64'(1));
        end
        @(negedge clk);
        clear_w();
        #1;
        check_val("w_idle_bvalid", 64'(bus.bvalid), 64'(0));
        check_val("w_idle_awready", 64'(bus.awready), 64'(0));
        check_val("err_multi", 64'(bus.err_multi), 64'(exp_multi));
    endtask

    task automatic do_read(input logic [N-1:0] mask, input logic [IW-1:0] id, input logic [7:0] arlen);
        int own, b, guard, nb;
        b = 0; guard = 0; nb = int'(arlen) + 1;
        if (mask != '0) begin
            own = lowest(mask);
            @(negedge clk);
            bus.m_arvalid = 1; bus.m_arid = id; bus.m_arlen = arlen; bus.s_arready = mask;
            #1 check_val("ar_claim_arready", 64'(bus.arready), 64'(1));
            if (popc(mask) > 1) exp_multi = 1'b1;
            while (b < nb && guard < 400) begin
                @(negedge clk);
                bus.m_arvalid = 0; bus.s_arready = '0;
                bus.s_rvalid = N'($urandom); bus.s_rlast = N'($urandom);
                bus.s_rlast[own] = (b == nb - 1);
                bus.s_rid = IDV'($urandom); bus.s_rresp = RSV'($urandom);
                bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
                bus.m_rready = 1'($urandom_range(0, 1));
                #1;
                check_val("r_own_rvalid", 64'(bus.rvalid), 64'(bus.s_rvalid[own]));
                check_val("r_own_rdata", 64'(bus.rdata), 64'(bus.s_rdata[own*DW +: DW]));
                check_val("r_own_rid", 64'(bus.rid), 64'(bus.s_rid[own*IW +: IW]));
                check_val("r_own_rresp", 64'(bus.rresp), 64'(bus.s_rresp[own*2 +: 2]));
                check_val("r_own_rlast", 64'(bus.rlast), 64'(b == nb - 1));
                if (bus.s_rvalid[own] && bus.m_rready) b++;
                guard++;
            end
            check_val("r_own_beats", 64'(b), 64'(nb));
        end else begin
            for (int c = 1; c <= TO; c++) begin
                @(negedge clk);
                bus.m_arvalid = 1; bus.m_arid = id; bus.m_arlen = arlen; bus.s_arready = '0;
                #1 check_val("ar_to_arready", 64'(bus.arready), 64'(c == TO));
            end
            exp_to = (exp_to < 16'hFFFF) ? exp_to + 1 : exp_to;
            while (b < nb && guard < 600) begin
                @(negedge clk);
                bus.m_arvalid = 0; bus.m_arid = IW'($urandom); bus.m_arlen = 8'($urandom);
                bus.m_rready = 1'($urandom_range(0, 1));
                #1;
                check_val("r_dec_rvalid", 64'(bus.rvalid), 64'(1));
                check_val("r_dec_rresp", 64'(bus.rresp), 64'(3));
                check_val("r_dec_rdata", 64'(bus.rdata), 64'(0));
                check_val("r_dec_rid", 64'(bus.rid), 64'(id));
                check_val("r_dec_rlast", 64'(bus.rlast), 64'(nb - b == 1));
                if (bus.m_rready) b++;
                guard++;
            end
            check_val("r_dec_beats", 64'(b), 64'(nb));
        end
        @(negedge clk);
        clear_r();
        #1;
        check_val("r_idle_rvalid", 64'(bus.rvalid), 64'(0));
        check_val("r_idle_arready", 64'(bus.arready), 64'(0));
        check_val("err_multi", 64'(bus.err_multi), 64'(exp_multi));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_w"}, 64'({bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp}), 64'(0));
        check_val({tag, "_r"}, 64'({bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rresp}), 64'(0));
        check_val({tag, "_rdata"}, 64'(bus.rdata), 64'(0));
        check_val({tag, "_err"}, 64'({bus.err_multi, bus.err_timeout_cnt}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_w();
        clear_r();
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 0;
        #1 check_all_zero("post_reset");

        do_write(4'b0100, 4'd5, 2);
        do_read(4'b1001, 4'd2, 8'd3);
        check_val("err_multi_sticky", 64'(bus.err_multi), 64'(1));
        do_write(4'b0000, 4'd9, 2);
        check_val("to_cnt_w", 64'(bus.err_timeout_cnt), 64'(exp_to));
        do_read(4'b0000, 4'd7, 8'd3);
        check_val("to_cnt_r", 64'(bus.err_timeout_cnt), 64'(exp_to));

        for (int i = 0; i < 16; i++) begin
            logic [N-1:0] m;
            m = ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(m, IW'($urandom), $urandom_range(1, 4));
            else
                do_read(m, IW'($urandom), 8'($urandom_range(0, 5)));
            check_val("to_cnt_rand", 64'(bus.err_timeout_cnt), 64'(exp_to));
        end

        fork
            do_write(4'b0010, 4'd4, 3);
            do_read(4'b0000, 4'd6, 8'd2);
        join
        check_val("to_cnt_concurrent", 64'(bus.err_timeout_cnt), 64'(exp_to));

        fork
            do_write(4'b0000, 4'd1, 1);
            do_read(4'b0000, 4'd8, 8'd1);
        join
        check_val("to_cnt_double", 64'(bus.err_timeout_cnt), 64'(exp_to));

        // Park read in an owned burst and write in decode-sink, then reset
        @(negedge clk);
        bus.m_arvalid = 1; bus.m_arid = 4'd3; bus.m_arlen = 8'd4; bus.s_arready = 4'b0010;
        @(negedge clk);
        bus.m_arvalid = 0; bus.s_arready = '0;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            bus.m_awvalid = 1; bus.m_awid = 4'd2;
        end
        @(negedge clk);
        bus.m_awvalid = 0; bus.s_rvalid = 4'b0010;
        #1;
        check_val("pre_rst_wready", 64'(bus.wready), 64'(1));
        check_val("pre_rst_rvalid", 64'(bus.rvalid), 64'(1));
        @(negedge clk);
        rst = 1;
        #1 check_all_zero("in_rst");
        @(negedge clk);
        rst = 0;
        exp_to = 0;
        exp_multi = 0;
        #1 check_all_zero("after_rst");
        bus.s_rvalid = '0;
        do_write(4'b0001, 4'd11, 2);
        do_read(4'b0001, 4'd12, 8'd2);
        check_val("to_cnt_final", 64'(bus.err_timeout_cnt), 64'(exp_to));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_resp_mux_n.md
Name: axi_resp_mux_n

Overview:
- Parametrised N-way combiner for AXI responses from the address-decoded register slaves hanging off one AXI master port.
- Replaces plain OR-combining with per-channel ownership tracking: the slave that accepts an address owns that channel until its response completes. Only the owner's response signals are forwarded.
- Adds multi-claim error detection and a decode-timeout that returns DECERR when no slave claims a request.
- One outstanding write and one outstanding read at a time.

Parameters:
N_SLV, 2, number of slave response ports (1..16)
ID_W, 4, AXI ID width
DATA_W, 32, read data width
TIMEOUT_CYC, 16, cycles awvalid/arvalid may stay unclaimed before DECERR (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_awvalid  in  1  master write-address valid
m_awid  in  ID_W  master write ID
m_wvalid  in  1  master write-data valid
m_wlast  in  1  master last write beat
m_bready  in  1  master write-response ready
m_arvalid  in  1  master read-address valid
m_arid  in  ID_W  master read ID
m_arlen  in  8  master read burst length
m_rready  in  1  master read-data ready
s_awready  in  N_SLV  per-slave awready
s_wready  in  N_SLV  per-slave wready
s_bid  in  N_SLV*ID_W  per-slave bid, slave k at [k*ID_W +: ID_W]
s_bresp  in  2*N_SLV  per-slave bresp
s_bvalid  in  N_SLV  per-slave bvalid
s_arready  in  N_SLV  per-slave arready
s_rid  in  N_SLV*ID_W  per-slave rid
s_rdata  in  N_SLV*DATA_W  per-slave rdata
s_rresp  in  2*N_SLV  per-slave rresp
s_rlast  in  N_SLV  per-slave rlast
s_rvalid  in  N_SLV  per-slave rvalid
awready wready bvalid arready rlast rvalid  out  1 each  merged master-side handshakes
bid rid  out  ID_W  merged IDs
bresp rresp  out  2  merged responses
rdata  out  DATA_W  merged read data
err_multi  out  1  sticky: more than one slave claimed the same address handshake
err_timeout_cnt  out  16  saturating count of DECERR timeouts

Behaviour:
- Reset: both FSMs idle; all outputs 0; timers 0; err_multi=0; err_timeout_cnt=0. Reset mid-transaction abandons it; there is no recovery of in-flight beats.
- Write FSM states: W_IDLE, W_OWN(owner idx), W_DEC_W, W_DEC_B.
  - W_IDLE: awready = OR(s_awready), combinational. wready=0, bvalid=0.
  - On m_awvalid & any s_awready: owner = lowest set index, registered. Next state W_OWN.
  - If popcount(s_awready)>1 at that handshake, err_multi is set (sticky).
- W_OWN: wready, bvalid, bid, bresp come combinationally from the owner only. Non-owner inputs are ignored. awready=0.
  - On bvalid & m_bready → W_IDLE next cycle.
  - An owner bvalid arriving before W beats finish is forwarded as-is.
- Write timeout:
  - In W_IDLE, the timer increments each cycle m_awvalid=1 with s_awready=0, and clears when m_awvalid=0.
  - When timer==TIMEOUT_CYC-1, awready=1 is driven locally for that cycle. Capture m_awid; go to W_DEC_W; err_timeout_cnt +1, saturating at 0xFFFF.
- W_DEC_W: wready=1; sink beats until m_wvalid & m_wlast → W_DEC_B.
- W_DEC_B: bvalid=1, bresp=2'b11, bid=captured ID; hold until m_bready → W_IDLE.
- Read FSM states: R_IDLE, R_OWN, R_DEC. Mirrors the write FSM (arready OR, lowest-index owner, err_multi, separate timer).
  - R_OWN forwards the owner's r* signals; exits on rvalid & rlast & m_rready.
  - Read timeout captures m_arid and beats=m_arlen+1 (9-bit). It shares err_timeout_cnt with writes; on simultaneous write and read timeouts the count increments by 2.
  - R_DEC: rvalid=1, rresp=2'b11, rdata=0, rid=captured; each accepted beat decrements; rlast=1 when remaining==1; last accepted beat → R_IDLE.
- Write and read FSMs are fully independent; simultaneous events on both are legal.
- Output valids must not glitch between owners: the owner select is registered, never combinational from current ready inputs.

Test Plan:
- N_SLV=4; slave 2 asserts awready with awvalid; slave 2 returns bid=5, bresp=0 → master sees bid=5, bresp=0. Garbage bvalid=1 from slave 1 during W_OWN is not forwarded. Back to idle after bready.
- Slaves 0 and 3 both assert arready on the same handshake → owner=0, err_multi=1 and stays 1. rdata comes only from slave 0; 4-beat burst ends on rlast.
- awvalid held 16 cycles with no claim → awready=1 on cycle 16. Two W beats sunk (wlast on 2nd); bvalid with bresp=3, bid=captured; err_timeout_cnt=1.
- Unclaimed read with arlen=3, arid=7 → exactly 4 beats rresp=3, rdata=0, rid=7, rlast on 4th only. Throttling m_rready on beat 2 holds the beat.
- Concurrent write to slave 1 and read timeout → both complete independently, no cross-channel corruption, err_timeout_cnt=1.
- rst asserted in W_DEC_W and R_OWN → next cycle all outputs 0, FSMs idle; a new claim by slave 0 works normally.
